// File: rtl/mem_axi_bridge_if.sv
// AXI3 single-beat channel bundle between the mem-stage bridge (master) and the memory slave.
interface mem_axi_bridge_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/mem_axi_bridge.sv
// Single-outstanding load/store bridge from the mem stage to an AXI3 slave.
// All AXI outputs and d_data_ok are registered; only d_stall is combinational.
//
//  state | meaning
//  IDLE  | waiting for d_req; request lines latched on acceptance
//  RD_A  | arvalid held until AR handshake
//  RD_D  | rready high, waiting for rvalid
//  WR_AW | awvalid/wvalid each held until their own handshake
//  WR_B  | bready high, waiting for bvalid
//  DONE  | one-cycle d_data_ok pulse, back to IDLE
module mem_axi_bridge #(
   parameter logic [3:0] ID = 4'd0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [2:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,
   output logic        d_data_ok,
   output logic        d_stall,
   mem_axi_bridge_if.master axi
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_t;

   state_t      state, state_nx;
   logic [31:0] addr_q, wdata_q;
   logic [2:0]  size_q;
   logic [3:0]  wstrb_q;
   logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, data_ok_q;
   logic        arvalid_nx, rready_nx, awvalid_nx, wvalid_nx, bready_nx, data_ok_nx;
   logic        aw_done, w_done, aw_done_nx, w_done_nx;
   logic        latch_en, rdata_en;
   logic        aw_seen, w_seen;

   always_comb begin
      state_nx   = state;
      arvalid_nx = 1'b0;
      rready_nx  = 1'b0;
      awvalid_nx = 1'b0;
      wvalid_nx  = 1'b0;
      bready_nx  = 1'b0;
      data_ok_nx = 1'b0;
      aw_done_nx = aw_done;
      w_done_nx  = w_done;
      latch_en   = 1'b0;
      rdata_en   = 1'b0;
      aw_seen    = aw_done | (awvalid_q & axi.awready);
      w_seen     = w_done  | (wvalid_q  & axi.wready);
      case (state)
         IDLE: begin
            if (d_req) begin
               latch_en = 1'b1;
               if (d_wr) begin
                  state_nx   = WR_AW;
                  awvalid_nx = 1'b1;
                  wvalid_nx  = 1'b1;
                  aw_done_nx = 1'b0;
                  w_done_nx  = 1'b0;
               end else begin
                  state_nx   = RD_A;
                  arvalid_nx = 1'b1;
               end
            end
         end
         RD_A: begin
            if (axi.arready) begin
               state_nx  = RD_D;
               rready_nx = 1'b1;
            end else begin
               arvalid_nx = 1'b1;
            end
         end
         RD_D: begin
            if (axi.rvalid) begin
               state_nx   = DONE;
               data_ok_nx = 1'b1;
               rdata_en   = 1'b1;
            end else begin
               rready_nx = 1'b1;
            end
         end
         WR_AW: begin
            // Either channel may handshake first; the flags remember which one already has.
            if (aw_seen && w_seen) begin
               state_nx   = WR_B;
               bready_nx  = 1'b1;
               aw_done_nx = 1'b0;
               w_done_nx  = 1'b0;
            end else begin
               awvalid_nx = ~aw_seen;
               wvalid_nx  = ~w_seen;
               aw_done_nx = aw_seen;
               w_done_nx  = w_seen;
            end
         end
         WR_B: begin
            if (axi.bvalid) begin
               state_nx   = DONE;
               data_ok_nx = 1'b1;
            end else begin
               bready_nx = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         data_ok_q <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
      end else begin
         state     <= state_nx;
         arvalid_q <= arvalid_nx;
         rready_q  <= rready_nx;
         awvalid_q <= awvalid_nx;
         wvalid_q  <= wvalid_nx;
         bready_q  <= bready_nx;
         data_ok_q <= data_ok_nx;
         aw_done   <= aw_done_nx;
         w_done    <= w_done_nx;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         d_rdata <= '0;
      end else begin
         if (latch_en) begin
            addr_q  <= d_addr;
            size_q  <= d_size;
            wdata_q <= d_wdata;
            wstrb_q <= d_wstrb;
         end
         if (rdata_en) d_rdata <= axi.rdata;
      end
   end

   // Response codes and rlast carry no information for a single-beat bridge.
   logic unused_resp;
   assign unused_resp = ^{axi.rresp, axi.rlast, axi.bresp};

   assign d_data_ok   = data_ok_q;
   assign d_stall     = d_req & ~data_ok_q;

   assign axi.arid    = ID;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = 8'd0;
   assign axi.arsize  = size_q;
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'd0;
   assign axi.arprot  = 3'd0;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

   assign axi.awid    = ID;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = 8'd0;
   assign axi.awsize  = size_q;
   assign axi.awburst = 2'b01;
   assign axi.awlock  = 2'b00;
   assign axi.awcache = 4'd0;
   assign axi.awprot  = 3'd0;
   assign axi.awvalid = awvalid_q;

   assign axi.wid     = ID;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wlast   = wvalid_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: cycle-exact slave stimulus, checks sampled on the falling edge.
module tb_mem_axi_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic        d_req, d_wr;
   logic [2:0]  d_size;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   logic [31:0] d_rdata;
   logic        d_data_ok, d_stall;

   int n_cmp = 0;
   int n_err = 0;
   int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, ok_cnt = 0;
   int ar0, aw0, ok0;

   mem_axi_bridge_if axi ();

   mem_axi_bridge #(.ID(4'd5)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .d_req     (d_req),
      .d_wr      (d_wr),
      .d_size    (d_size),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wstrb   (d_wstrb),
      .d_rdata   (d_rdata),
      .d_data_ok (d_data_ok),
      .d_stall   (d_stall),
      .axi       (axi)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (axi.arvalid && axi.arready) ar_cnt <= ar_cnt + 1;
      if (axi.awvalid && axi.awready) aw_cnt <= aw_cnt + 1;
      if (axi.wvalid  && axi.wready)  w_cnt  <= w_cnt + 1;
      if (d_data_ok)                  ok_cnt <= ok_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      resetn = 1'b0;
      d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      axi.arready = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;
      axi.awready = 0; axi.wready = 0; axi.bresp = 0; axi.bvalid = 0;
      repeat (2) cyc();

      check("rst_arvalid", axi.arvalid, 0);
      check("rst_awvalid", axi.awvalid, 0);
      check("rst_wvalid",  axi.wvalid, 0);
      check("rst_rready",  axi.rready, 0);
      check("rst_bready",  axi.bready, 0);
      check("rst_data_ok", d_data_ok, 0);
      check("rst_rdata",   d_rdata, 0);
      check("rst_araddr",  axi.araddr, 0);
      check("const_arid",  axi.arid, 5);
      check("const_awburst", axi.awburst, 2'b01);
      check("const_arlen", axi.arlen, 0);
      resetn = 1'b1;

      // Load, fast slave
      d_req = 1; d_wr = 0; d_addr = 32'h1000_0004; d_size = 3'd2; axi.arready = 1;
      cyc();
      check("ld1_arvalid", axi.arvalid, 1);
      check("ld1_araddr",  axi.araddr, 32'h1000_0004);
      check("ld1_arsize",  axi.arsize, 2);
      check("ld1_stall_a", d_stall, 1);
      check("ld1_rready_a", axi.rready, 0);
      cyc();
      check("ld1_arvalid_d", axi.arvalid, 0);
      check("ld1_rready",  axi.rready, 1);
      check("ld1_ok_early", d_data_ok, 0);
      check("ld1_stall_d", d_stall, 1);
      axi.rvalid = 1; axi.rdata = 32'hDEAD_BEEF; axi.arready = 0;
      cyc();
      check("ld1_data_ok", d_data_ok, 1);
      check("ld1_rdata",   d_rdata, 32'hDEAD_BEEF);
      check("ld1_stall_ok", d_stall, 0);
      check("ld1_rready_ok", axi.rready, 0);
      axi.rvalid = 0; d_req = 0;
      cyc();
      check("ld1_ok_once", d_data_ok, 0);

      // Store, AW accepted a cycle after valid, W four cycles after; d_req dropped mid-flight
      d_req = 1; d_wr = 1; d_addr = 32'h2000_0008; d_wdata = 32'h0000_AB00;
      d_wstrb = 4'b0010; d_size = 3'd0;
      cyc();
      check("st_awvalid", axi.awvalid, 1);
      check("st_wvalid",  axi.wvalid, 1);
      check("st_wlast",   axi.wlast, 1);
      check("st_awaddr",  axi.awaddr, 32'h2000_0008);
      check("st_awsize",  axi.awsize, 0);
      check("st_wdata",   axi.wdata, 32'h0000_AB00);
      check("st_wstrb",   axi.wstrb, 4'b0010);
      axi.awready = 1;
      cyc();
      check("st_awvalid_drop", axi.awvalid, 0);
      check("st_wvalid_hold2", axi.wvalid, 1);
      check("st_bready_early2", axi.bready, 0);
      axi.awready = 0; d_req = 0; d_wdata = 32'hFFFF_FFFF;
      cyc();
      check("st_wvalid_hold3", axi.wvalid, 1);
      check("st_wdata_stable", axi.wdata, 32'h0000_AB00);
      check("st_stall_noreq", d_stall, 0);
      cyc();
      check("st_wvalid_hold4", axi.wvalid, 1);
      check("st_bready_early4", axi.bready, 0);
      axi.wready = 1;
      cyc();
      check("st_wvalid_drop", axi.wvalid, 0);
      check("st_bready", axi.bready, 1);
      check("st_ok_early", d_data_ok, 0);
      axi.wready = 0; axi.bvalid = 1;
      cyc();
      check("st_data_ok", d_data_ok, 1);
      check("st_bready_drop", axi.bready, 0);
      check("st_rdata_kept", d_rdata, 32'hDEAD_BEEF);
      axi.bvalid = 0;
      cyc();
      check("st_aw_count", aw_cnt, 1);
      check("st_w_count",  w_cnt, 1);

      // AR backpressure with the request address changing underneath; SLVERR read
      ar0 = ar_cnt;
      d_req = 1; d_wr = 0; d_addr = 32'h3000_0010; d_size = 3'd1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("bp_arvalid", axi.arvalid, 1);
         check("bp_araddr",  axi.araddr, 32'h3000_0010);
         check("bp_arsize",  axi.arsize, 1);
         d_addr = 32'h3000_0100 + i; d_size = 3'd2;
      end
      axi.arready = 1;
      cyc();
      check("bp_arvalid_drop", axi.arvalid, 0);
      check("bp_single_ar", ar_cnt - ar0, 1);
      axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h1234_5678; axi.rresp = 2'b10;
      cyc();
      check("err_r_data_ok", d_data_ok, 1);
      check("err_r_rdata",   d_rdata, 32'h1234_5678);
      axi.rvalid = 0; axi.rresp = 0; d_req = 0;
      cyc();

      // Store with AW and W accepted in the same cycle; DECERR write response
      axi.awready = 1; axi.wready = 1;
      d_req = 1; d_wr = 1; d_addr = 32'h2000_0040; d_wdata = 32'h5566_7788; d_wstrb = 4'hF; d_size = 3'd2;
      cyc();
      check("both_awvalid", axi.awvalid, 1);
      check("both_wvalid",  axi.wvalid, 1);
      cyc();
      check("both_bready", axi.bready, 1);
      check("both_awvalid_drop", axi.awvalid, 0);
      check("both_wvalid_drop",  axi.wvalid, 0);
      axi.awready = 0; axi.wready = 0; axi.bvalid = 1; axi.bresp = 2'b11;
      cyc();
      check("err_b_data_ok", d_data_ok, 1);
      axi.bvalid = 0; axi.bresp = 0; d_req = 0;
      cyc();

      // Reset in RD_D, then a fresh load
      d_req = 1; d_wr = 0; d_addr = 32'h4000_0000; d_size = 3'd2; axi.arready = 1;
      cyc();
      cyc();
      check("rr_rready_pre", axi.rready, 1);
      resetn = 0; d_req = 0; axi.arready = 0;
      #1;
      check("rr_rready",  axi.rready, 0);
      check("rr_arvalid", axi.arvalid, 0);
      check("rr_data_ok", d_data_ok, 0);
      check("rr_rdata",   d_rdata, 0);
      cyc();
      resetn = 1;
      cyc();
      check("rr_no_ok", d_data_ok, 0);
      d_req = 1; d_addr = 32'h5000_0000; axi.arready = 1;
      cyc();
      check("rr2_araddr", axi.araddr, 32'h5000_0000);
      cyc();
      axi.rvalid = 1; axi.rdata = 32'hCAFE_F00D; axi.arready = 0;
      cyc();
      check("rr2_data_ok", d_data_ok, 1);
      check("rr2_rdata",   d_rdata, 32'hCAFE_F00D);
      axi.rvalid = 0; d_req = 0;
      cyc();

      // Back-to-back: store then load with d_req held high throughout
      ar0 = ar_cnt; aw0 = aw_cnt; ok0 = ok_cnt;
      axi.awready = 1; axi.wready = 1; axi.arready = 1;
      d_req = 1; d_wr = 1; d_addr = 32'h6000_0000; d_wdata = 32'h0000_0011; d_wstrb = 4'h1; d_size = 3'd0;
      cyc();
      check("b2b_awvalid", axi.awvalid, 1);
      cyc();
      axi.bvalid = 1;
      cyc();
      check("b2b_ok1", d_data_ok, 1);
      axi.bvalid = 0;
      d_wr = 0; d_addr = 32'h6000_0020; d_size = 3'd2;
      cyc();
      check("b2b_idle_ok", d_data_ok, 0);
      check("b2b_idle_ar", axi.arvalid, 0);
      check("b2b_idle_aw", axi.awvalid, 0);
      check("b2b_idle_stall", d_stall, 1);
      cyc();
      check("b2b_arvalid", axi.arvalid, 1);
      check("b2b_araddr",  axi.araddr, 32'h6000_0020);
      cyc();
      axi.rvalid = 1; axi.rdata = 32'h0BAD_CAFE;
      cyc();
      check("b2b_ok2",   d_data_ok, 1);
      check("b2b_rdata", d_rdata, 32'h0BAD_CAFE);
      axi.rvalid = 0; d_req = 0; axi.arready = 0; axi.awready = 0; axi.wready = 0;
      cyc();
      cyc();
      check("b2b_ok_count", ok_cnt - ok0, 2);
      check("b2b_ar_count", ar_cnt - ar0, 1);
      check("b2b_aw_count", aw_cnt - aw0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_axi_bridge.md
# mem_axi_bridge

Single-outstanding data-access bridge downstream of the `mem` stage. It accepts one load or store request at a time on the stage's `d_addr`/`d_wdata`/`d_size` request lines, plus a request strobe and byte strobes. It issues that request as a single-beat AXI3 transaction and returns read data with a one-cycle completion pulse. It also drives the stall the `mem` stage uses to hold the pipeline while the transaction is in flight.

## Interface
Parameters:
- `ID`, 4'd0: value driven on `arid`/`awid`/`wid`.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `d_req`  in  1  request valid from `mem`; held high until `d_data_ok`.
- `d_wr`  in  1  1 = store, 0 = load.
- `d_size`  in  3  AXI size encoding: 0 = byte, 1 = half, 2 = word.
- `d_addr`  in  32  byte address, passed unmodified.
- `d_wdata`  in  32  store data, already lane-aligned by `mem`.
- `d_wstrb`  in  4  store byte enables.
- `d_rdata`  out  32  registered read word.
- `d_data_ok`  out  1  one-cycle completion pulse.
- `d_stall`  out  1  `d_req & ~d_data_ok` (combinational).
- AR channel: `araddr` out 32, `arsize` out 3, `arvalid` out 1, `arready` in 1.
- R channel: `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- AW channel: `awaddr` out 32, `awsize` out 3, `awvalid` out 1, `awready` in 1.
- W channel: `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1.
- B channel: `bresp` in 2, `bvalid` in 1, `bready` out 1.
- ID outputs: `arid`, `awid`, `wid`, each out 4, constant `ID`.
- Burst fields: `arlen`/`awlen` out 8 = 0; `arburst`/`awburst` out 2 = 2'b01.
- Attribute fields: `arlock`/`awlock` out 2 = 0; `arcache`/`awcache` out 4 = 0; `arprot`/`awprot` out 3 = 0.

## Operation
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- Acceptance:
  - In IDLE with `d_req=1`, latch `d_addr`, `d_size`, `d_wdata`, `d_wstrb` and `d_wr`.
  - Go to RD_A if `d_wr=0`, else WR_AW.
  - The request lines are ignored in every other state; later changes have no effect.
- RD_A: `arvalid=1` with the latched address and size. On `arvalid & arready`, go to RD_D.
- RD_D:
  - `rready=1`.
  - On `rvalid`, capture `rdata` into `d_rdata` and go to DONE.
  - `rresp` and `rlast` are ignored; SLVERR/DECERR still complete normally.
- WR_AW:
  - Entered with both `awvalid=1` and `wvalid=1`.
  - Each valid drops independently after its own handshake, tracked by `aw_done`/`w_done` flags.
  - Go to WR_B when both are done; this includes both handshakes in the same cycle, or the second handshake arriving while the first is already recorded.
  - `wlast=1` whenever `wvalid=1`.
- WR_B: `bready=1`. On `bvalid`, go to DONE; `bresp` is ignored.
- DONE:
  - `d_data_ok=1` for exactly this cycle, then go to IDLE unconditionally.
  - A `d_req` still high in DONE is not accepted. `mem` advances at this edge and presents the next request in IDLE.
- `d_rdata` holds its last captured value until the next read completes. Stores do not alter it.

## Timing
- Reset values:
  - State is IDLE.
  - All valid and ready outputs, `d_data_ok`, `aw_done` and `w_done` are 0.
  - `d_rdata`, latched address, data and strobes are 0.
- All AXI outputs and `d_data_ok` are registered. Only `d_stall` is combinational.
- Minimum latency, with slave ready and response the next cycle: acceptance edge T, then `arvalid`/`awvalid` high in T+1, handshake-phase in T+2, `d_data_ok` in T+3. That is a 3-cycle turnaround; back-to-back requests therefore start every 4 cycles.
- Valid stability: once asserted, `arvalid`/`awvalid`/`wvalid` and their payload stay stable until handshake, independent of `d_req`.
- `resetn` low in any state asynchronously forces IDLE and all outputs to reset values. The in-flight transaction is abandoned, since the slave shares the reset. No `d_data_ok` is produced for it.
- `d_req=0` mid-transaction has no effect; the transaction completes and `d_data_ok` still pulses.

## Test plan
- Load, fast slave: `d_addr=0x1000_0004`, `d_size=2`, `arready=1`, `rvalid` one cycle after AR with `rdata=0xDEADBEEF` -> `araddr=0x1000_0004`, `arsize=2`, `d_data_ok` 3 cycles after acceptance, `d_rdata=0xDEADBEEF`; `d_stall` high until that cycle.
- Store, staggered channels: `d_wdata=0x0000_AB00`, `d_wstrb=4'b0010`, `d_size=0`, `awready` 1 cycle later and `wready` 4 cycles later -> `awvalid` drops after its handshake, `wvalid` held until cycle 4, `bready` only after both, `d_data_ok` the cycle after `bvalid`.
- AR backpressure: hold `arready=0` for 5 cycles while changing `d_addr` -> `araddr` and `arvalid` stable throughout, latched address used, single AR issued.
- Error responses: `rresp=2'b10` and `bresp=2'b11` -> both transactions complete with `d_data_ok`; read data is captured regardless.
- Reset mid-read: deassert `resetn` while in RD_D -> next sample shows IDLE, `rready=0`, `arvalid=0`, `d_data_ok=0`. A fresh load after reset release completes normally.
- Back-to-back: `d_req` held high across a store then a load -> exactly one `d_data_ok` per request, no re-issue during DONE, second AR starts the cycle after IDLE acceptance.
